decode_queue: RTL

- Instruction buffer between fetch and issue, parametrised in depth, fetch width and issue width.
- Accepts up to IN_W fetched instructions per cycle.
- Pre-decodes each instruction at enqueue into an ALU control code and a branch-judge control code, and stores the codes with the instruction.
- Presents up to OUT_W oldest entries per cycle to issue. Issue consumes any in-order prefix of them.
- Supports a single-cycle flush for branch mispredict and exception redirect.

---
 rtl/decode_queue_pkg.sv | 101 ++++++++++
 rtl/decode_queue_insn_predecode.sv | 78 +++++++
 rtl/decode_queue.sv | 113 +++++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// Shared constants for the decode queue: control-code width, ALU/branch
// control encodings and the MIPS opcode/funct/rt field values.
package decode_queue_pkg;

  localparam int unsigned CTRL_W = 5;

  typedef enum logic [CTRL_W-1:0] {
    ALU_DONOTHING = 5'd0,
    ALU_AND       = 5'd1,
    ALU_OR        = 5'd2,
    ALU_XOR       = 5'd3,
    ALU_NOR       = 5'd4,
    ALU_ADD       = 5'd5,
    ALU_SUB       = 5'd6,
    ALU_ADDU      = 5'd7,
    ALU_SUBU      = 5'd8,
    ALU_SLT       = 5'd9,
    ALU_SLTU      = 5'd10,
    ALU_DIV       = 5'd11,
    ALU_DIVU      = 5'd12,
    ALU_MULT      = 5'd13,
    ALU_MUL       = 5'd14,
    ALU_MULTU     = 5'd15,
    ALU_SLL       = 5'd16,
    ALU_SRL       = 5'd17,
    ALU_SRA       = 5'd18,
    ALU_SLLV      = 5'd19,
    ALU_SRLV      = 5'd20,
    ALU_SRAV      = 5'd21,
    ALU_MTHI      = 5'd22,
    ALU_MTLO      = 5'd23,
    ALU_LUI       = 5'd24,
    ALU_EQ        = 5'd25,
    ALU_NEQ       = 5'd26,
    ALU_GTZ       = 5'd27,
    ALU_LEZ       = 5'd28,
    ALU_LTZ       = 5'd29,
    ALU_GEZ       = 5'd30
  } alu_code_e;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LWL      = 6'h22;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_LWR      = 6'h26;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SWL      = 6'h2A;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_SWR      = 6'h2E;

  // SPECIAL / SPECIAL2 funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

endpackage

// File: rtl/decode_queue_insn_predecode.sv
// Combinational pre-decode of one instruction word into ALU and
// branch-judge control codes.
module insn_predecode
  import decode_queue_pkg::*;
(
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [CTRL_W-1:0] br_ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];

  // Decode opcode/funct/rt into the two control codes
  always_comb begin
    alu_ctrl = ALU_DONOTHING;
    br_ctrl  = ALU_DONOTHING;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_AND:   alu_ctrl = ALU_AND;
          FN_OR:    alu_ctrl = ALU_OR;
          FN_XOR:   alu_ctrl = ALU_XOR;
          FN_NOR:   alu_ctrl = ALU_NOR;
          FN_ADD:   alu_ctrl = ALU_ADD;
          FN_SUB:   alu_ctrl = ALU_SUB;
          FN_ADDU:  alu_ctrl = ALU_ADDU;
          FN_SUBU:  alu_ctrl = ALU_SUBU;
          FN_SLT:   alu_ctrl = ALU_SLT;
          FN_SLTU:  alu_ctrl = ALU_SLTU;
          FN_DIV:   alu_ctrl = ALU_DIV;
          FN_DIVU:  alu_ctrl = ALU_DIVU;
          FN_MULT:  alu_ctrl = ALU_MULT;
          FN_MULTU: alu_ctrl = ALU_MULTU;
          FN_SLL:   alu_ctrl = ALU_SLL;
          FN_SRL:   alu_ctrl = ALU_SRL;
          FN_SRA:   alu_ctrl = ALU_SRA;
          FN_SLLV:  alu_ctrl = ALU_SLLV;
          FN_SRLV:  alu_ctrl = ALU_SRLV;
          FN_SRAV:  alu_ctrl = ALU_SRAV;
          FN_MTHI:  alu_ctrl = ALU_MTHI;
          FN_MTLO:  alu_ctrl = ALU_MTLO;
          default:  ;
        endcase
      end
      OP_SPECIAL2: if (funct == FN_MUL) alu_ctrl = ALU_MUL;
      OP_ADDI:     alu_ctrl = ALU_ADD;
      OP_ADDIU:    alu_ctrl = ALU_ADDU;
      OP_SLTI:     alu_ctrl = ALU_SLT;
      OP_SLTIU:    alu_ctrl = ALU_SLTU;
      OP_ANDI:     alu_ctrl = ALU_AND;
      OP_XORI:     alu_ctrl = ALU_XOR;
      OP_ORI:      alu_ctrl = ALU_OR;
      OP_LUI:      alu_ctrl = ALU_LUI;
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:
                   alu_ctrl = ALU_ADDU;
      OP_BEQ:      br_ctrl = ALU_EQ;
      OP_BNE:      br_ctrl = ALU_NEQ;
      OP_BGTZ:     br_ctrl = ALU_GTZ;
      OP_BLEZ:     br_ctrl = ALU_LEZ;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BLTZAL: br_ctrl = ALU_LTZ;
          RT_BGEZ, RT_BGEZAL: br_ctrl = ALU_GEZ;
          default:            ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Circular instruction buffer between fetch and issue. Instructions are
// pre-decoded on enqueue; the oldest OUT_W entries are presented to issue.
module decode_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 2,
  parameter int unsigned CTRL_W = decode_queue_pkg::CTRL_W
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic [IN_W-1:0]               in_valid,
  input  logic [32*IN_W-1:0]            in_instr,
  input  logic [32*IN_W-1:0]            in_pc,
  output logic                          in_ready,
  output logic [OUT_W-1:0]              out_valid,
  output logic [32*OUT_W-1:0]           out_instr,
  output logic [32*OUT_W-1:0]           out_pc,
  output logic [CTRL_W*OUT_W-1:0]       out_alu_control,
  output logic [CTRL_W*OUT_W-1:0]       out_branch_judge,
  input  logic [OUT_W-1:0]              out_pop,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  n_push;
  logic [CNT_W-1:0]  n_pop;

  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];
  logic [CTRL_W-1:0] alu_mem   [DEPTH];
  logic [CTRL_W-1:0] br_mem    [DEPTH];

  logic [CTRL_W-1:0] pd_alu [IN_W];
  logic [CTRL_W-1:0] pd_br  [IN_W];

  for (genvar g = 0; g < IN_W; g++) begin : g_pd
    insn_predecode u_pd (
      .instr    (in_instr[32*g +: 32]),
      .alu_ctrl (pd_alu[g]),
      .br_ctrl  (pd_br[g])
    );
  end

  // Room for a full fetch group, judged on current occupancy only
  assign in_ready = (count <= CNT_W'(DEPTH - IN_W));

  // Thermometer valid mask and push/pop counts
  always_comb begin
    out_valid = '0;
    n_push    = '0;
    n_pop     = '0;
    for (int unsigned j = 0; j < OUT_W; j++) begin
      out_valid[j] = (count > CNT_W'(j));
    end
    for (int unsigned i = 0; i < IN_W; i++) begin
      n_push = n_push + CNT_W'(in_valid[i] & in_ready);
    end
    for (int unsigned j = 0; j < OUT_W; j++) begin
      n_pop = n_pop + CNT_W'(out_pop[j] & out_valid[j]);
    end
  end

  // Pointer and occupancy registers; flush overrides push and pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(n_pop);
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      count  <= count + n_push - n_pop;
    end
  end

  // Entry storage write of pre-decoded fetch lanes
  always_ff @(posedge clk) begin
    if (!flush && in_ready) begin
      for (int unsigned i = 0; i < IN_W; i++) begin
        if (in_valid[i]) begin
          instr_mem[wr_ptr + PTR_W'(i)] <= in_instr[32*i +: 32];
          pc_mem[wr_ptr + PTR_W'(i)]    <= in_pc[32*i +: 32];
          alu_mem[wr_ptr + PTR_W'(i)]   <= pd_alu[i];
          br_mem[wr_ptr + PTR_W'(i)]    <= pd_br[i];
        end
      end
    end
  end

  // Zero-latency read of the oldest OUT_W entries
  always_comb begin
    out_instr        = '0;
    out_pc           = '0;
    out_alu_control  = '0;
    out_branch_judge = '0;
    for (int unsigned j = 0; j < OUT_W; j++) begin
      out_instr[32*j +: 32]            = instr_mem[rd_ptr + PTR_W'(j)];
      out_pc[32*j +: 32]               = pc_mem[rd_ptr + PTR_W'(j)];
      out_alu_control[CTRL_W*j +: CTRL_W]  = alu_mem[rd_ptr + PTR_W'(j)];
      out_branch_judge[CTRL_W*j +: CTRL_W] = br_mem[rd_ptr + PTR_W'(j)];
    end
  end

endmodule
